buf_loader: RTL and testbench

BUF_LOADER -- requirements
Module: buf_loader

---
 rtl/buf_loader_pkg.sv | 16 +
 rtl/buf_loader.sv | 149 ++++++++++++++
 tb/tb_buf_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/buf_loader_pkg.sv
// buf_loader_pkg
//   Shared definitions for the sample-buffer loader and the playback address
//   controller: FSM state encoding and default buffer geometry.
package buf_loader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  // The playback controller decodes these codes directly, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/buf_loader.sv
// buf_loader
//   Streams samples into the DAC sample buffer. A start pulse opens a load
//   window. Accepted beats are written to consecutive buffer addresses from 0.
//   The window closes on s_last, when the buffer fills (overflow), or on abort.
//   While a load is active, we holds the playback address controller idle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no load; we=0, s_ready=0
// LOAD   | accepting beats; we=1, s_ready=1
// FINISH | one cycle; we=1, done=1, max_addr already valid
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   start, abort             begin load (IDLE only) / cancel load (LOAD only)
//   s_data/s_valid/s_last    sample stream in; s_ready is the handshake back
//   bram_addr/din/wr         registered buffer write port
//   we                       playback hold
//   max_addr                 last written address of the last completed load
//   done                     one-cycle pulse in FINISH
//   overflow                 sticky: last load was truncated at DEPTH
module buf_loader
  import buf_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_wr,
  output logic              we,
  output logic [31:0]       max_addr,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  logic              bram_wr_q, bram_wr_d;
  logic [31:0]       max_addr_q, max_addr_d;
  logic              overflow_q, overflow_d;

  logic accept;
  logic at_end;
  logic load_start;
  logic load_end;

  assign accept     = (state_q == ST_LOAD) && s_valid;
  assign at_end     = (ptr_q == PTR_MAX);
  assign load_start = (state_q == ST_IDLE) && start;
  // Abort takes priority over a terminating beat in the same cycle.
  assign load_end   = accept && (s_last || at_end) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    we      = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        we      = 1'b1;
        if (abort)         state_d = ST_IDLE;
        else if (load_end) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        we      = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    bram_wr_d   = accept;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    max_addr_d  = max_addr_q;
    overflow_d  = overflow_q;

    if (load_start) begin
      ptr_d      = '0;
      overflow_d = 1'b0;
    end

    // A beat accepted together with abort is still written.
    if (accept) begin
      bram_addr_d = ptr_q;
      bram_din_d  = s_data;
      // Saturate at the last address instead of wrapping.
      if (!at_end) ptr_d = ptr_q + 1'b1;
    end

    if (load_end) begin
      max_addr_d = 32'(ptr_q);
      if (!s_last) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      bram_wr_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      max_addr_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      bram_wr_q   <= bram_wr_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      max_addr_q  <= max_addr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bram_wr   = bram_wr_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign max_addr  = max_addr_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_buf_loader.sv
// tb_buf_loader
//   Directed scenarios against a 16-deep buffer (ADDR_W=4). Each scenario pushes
//   its hand-computed buffer writes into a queue. A negedge monitor pops and
//   compares every write the DUT issues, counts done pulses and checks that
//   we drops in the cycle after done.
module tb_buf_loader;
  localparam int AW = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_wr;
  logic          we;
  logic [31:0]   max_addr;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  wr_t wq[$];

  buf_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_wr(bram_wr),
    .we(we), .max_addr(max_addr), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard side.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_wr) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", 32'(bram_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(bram_addr), 32'(e.a));
          chk("wr_data", 32'(bram_din), 32'(e.d));
        end
      end
      if (prev_done) chk("we_after_done", 32'(we), 32'd0);
      if (done) done_cnt++;
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = AW'(a);
    e.d = DW'(d);
    wq.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("we_in_load", 32'(we), 32'd1);
    chk("s_ready_in_load", 32'(s_ready), 32'd1);
  endtask

  task automatic beat(input int d, input logic last, input logic vld);
    s_valid = vld;
    s_data  = DW'(d);
    s_last  = last;
    cyc();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wrap_up(input string tag, input int exp_done, input int exp_max, input int exp_ovf, input int d0);
    repeat (4) cyc();
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({tag, "_max_addr"}, max_addr, 32'(exp_max));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_pending_writes"}, 32'(wq.size()), 32'd0);
    chk({tag, "_we_idle"}, 32'(we), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #12;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_bram_wr", 32'(bram_wr), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    chk("rst_bram_din", 32'(bram_din), 32'd0);
    chk("rst_max_addr", max_addr, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Abort after 3 beats: writes happen, no done, max_addr stays 0.
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 3; i++) begin push(i, 16'h0010 + i); beat(16'h0010 + i, 1'b0, 1'b1); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    wrap_up("abort", 0, 0, 0, d0);

    // Basic load of 4 beats.
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 4; i++) begin push(i, i + 1); beat(i + 1, (i == 3), 1'b1); end
    chk("basic_done_pulse", 32'(done), 32'd1);
    chk("basic_we_in_finish", 32'(we), 32'd1);
    chk("basic_max_in_finish", max_addr, 32'd3);
    wrap_up("basic", 1, 3, 0, d0);

    // Overflow: 20 beats into 16 entries.
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) push(i, 16'h0100 + i);
      else chk("ovf_s_ready_low", 32'(s_ready), 32'd0);
      beat(16'h0100 + i, 1'b0, 1'b1);
    end
    wrap_up("ovf", 1, 15, 1, d0);

    // s_valid toggling: beats 0,2,4,6,8 accepted; start clears overflow.
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) push(k / 2, 16'h0200 + k);
      beat(16'h0200 + k, (k == 8), (k % 2 == 0));
    end
    wrap_up("toggle", 1, 4, 0, d0);

    // start pulsed during LOAD has no effect.
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 4; i++) begin
      push(i, 16'h0300 + i);
      start = (i == 2);
      beat(16'h0300 + i, (i == 3), 1'b1);
      start = 1'b0;
    end
    wrap_up("start_in_load", 1, 3, 0, d0);

    // abort together with s_last: write occurs, abort wins.
    d0 = done_cnt;
    do_start();
    push(0, 16'h0ABC);
    abort = 1'b1;
    beat(16'h0ABC, 1'b1, 1'b1);
    abort = 1'b0;
    chk("abort_last_done", 32'(done), 32'd0);
    wrap_up("abort_last", 0, 3, 0, d0);

    // Reset mid-load.
    do_start();
    push(0, 16'h0400);
    beat(16'h0400, 1'b0, 1'b1);
    beat(16'h0401, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_bram_wr", 32'(bram_wr), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_max_addr", max_addr, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 2; i++) begin push(i, 16'h0500 + i); beat(16'h0500 + i, (i == 1), 1'b1); end
    wrap_up("after_rst", 1, 1, 0, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
